// File: rtl/controle_varredura_pwm_pkg.sv
// Shared types and constants for the PWM width sweep sequencer.
// Holds state encodings, position codes and counter sizing helpers.
package controle_varredura_pwm_pkg;

  typedef enum logic [1:0] {
    PARADO = 2'b00,
    ARMADO = 2'b01,
    ATIVO  = 2'b10
  } estado_t;

  localparam logic [1:0] POS_00 = 2'b00;
  localparam logic [1:0] POS_01 = 2'b01;
  localparam logic [1:0] POS_10 = 2'b10;
  localparam logic [1:0] POS_11 = 2'b11;

  function automatic int cont_w(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Ping-pong step: ends bounce instead of wrapping.
  function automatic logic [2:0] proximo(
    input logic [1:0] larg,
    input logic       desc
  );
    logic [1:0] n;
    logic       s;
    n = desc ? larg - 2'd1 : larg + 2'd1;
    s = desc ? (n != POS_00) : (n == POS_11);
    return {s, n};
  endfunction

endpackage

// File: rtl/controle_varredura_pwm_contador.sv
// Modulo-M counter with synchronous clear and count enable.
// fim flags the terminal count M-1.
import controle_varredura_pwm_pkg::*;

module contador_m #(
  parameter int M = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  localparam int W = cont_w(M);
  localparam logic [W-1:0] ULT = W'(M - 1);

  logic [W-1:0] valor_q;

  assign fim = (valor_q == ULT);

  always_ff @(posedge clock) begin
    if (reset || zera) begin
      valor_q <= '0;
    end else if (conta) begin
      valor_q <= fim ? '0 : valor_q + W'(1);
    end
  end

endmodule

// File: rtl/controle_varredura_pwm.sv
// Sweeps the PWM width select back and forth, one step per
// PERIODOS_POR_PASSO PWM periods, aligned to period boundaries.
import controle_varredura_pwm_pkg::*;

module controle_varredura_pwm #(
  parameter int CONF_PERIODO       = 1250,
  parameter int PERIODOS_POR_PASSO = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  output logic [1:0] largura,
  output logic       sentido,
  output logic       fim_posicao,
  output logic [1:0] db_estado
);

  estado_t    state_q, state_d;
  logic [1:0] largura_q;
  logic       sentido_q;
  logic       fim_q;
  logic       fim_clk;
  logic       fim_per;
  logic       avanca;
  logic [2:0] prox;

  // Period counter free-runs to stay in phase with the PWM generator.
  contador_m #(.M(CONF_PERIODO)) u_cnt_clk (
    .clock (clock),
    .reset (reset),
    .zera  (1'b0),
    .conta (1'b1),
    .fim   (fim_clk)
  );

  contador_m #(.M(PERIODOS_POR_PASSO)) u_cnt_per (
    .clock (clock),
    .reset (reset),
    .zera  (state_q != ATIVO),
    .conta ((state_q == ATIVO) && fim_clk),
    .fim   (fim_per)
  );

  always_comb begin
    state_d = state_q;
    avanca  = 1'b0;
    unique case (state_q)
      PARADO: begin
        if (ligar) state_d = ARMADO;
      end
      ARMADO: begin
        if (!ligar)       state_d = PARADO;
        else if (fim_clk) state_d = ATIVO;
      end
      ATIVO: begin
        if (!ligar)                  state_d = PARADO;
        else if (fim_clk && fim_per) avanca  = 1'b1;
      end
      default: state_d = PARADO;
    endcase
  end

  assign prox = proximo(largura_q, sentido_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= PARADO;
      largura_q <= POS_00;
      sentido_q <= 1'b0;
      fim_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      fim_q   <= avanca;
      if (avanca) begin
        largura_q <= prox[1:0];
        sentido_q <= prox[2];
      end
    end
  end

  assign largura     = largura_q;
  assign sentido     = sentido_q;
  assign fim_posicao = fim_q;
  assign db_estado   = state_q;

endmodule

// File: tb/tb_controle_varredura_pwm.sv
// Directed bench for the sweep sequencer: default sizing plus a
// small-parameter instance sharing the same clock.
module tb_controle_varredura_pwm;

  logic       clk = 1'b0;
  logic       reset, ligar;
  logic [1:0] largura, db_estado;
  logic       sentido, fim_posicao;
  logic       reset_s, ligar_s;
  logic [1:0] largura_s, db_s;
  logic       sentido_s, fim_s;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  controle_varredura_pwm dut (
    .clock       (clk),
    .reset       (reset),
    .ligar       (ligar),
    .largura     (largura),
    .sentido     (sentido),
    .fim_posicao (fim_posicao),
    .db_estado   (db_estado)
  );

  controle_varredura_pwm #(
    .CONF_PERIODO       (4),
    .PERIODOS_POR_PASSO (1)
  ) dut_s (
    .clock       (clk),
    .reset       (reset_s),
    .ligar       (ligar_s),
    .largura     (largura_s),
    .sentido     (sentido_s),
    .fim_posicao (fim_s),
    .db_estado   (db_s)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ligar = 1'b0;
    step();
    step();
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (largura !== 2'b00) begin errors++; $display("FAIL rst_largura got=%0h exp=0", largura); end
    checks++; if (sentido !== 1'b0) begin errors++; $display("FAIL rst_sentido got=%0b exp=0", sentido); end
    checks++; if (fim_posicao !== 1'b0) begin errors++; $display("FAIL rst_fim got=%0b exp=0", fim_posicao); end
    checks++; if (db_estado !== 2'b00) begin errors++; $display("FAIL rst_estado got=%0h exp=0", db_estado); end
  endtask

  task automatic test_idle();
    int bad = 0;
    while (cyc < 10000) begin
      step();
      if (largura !== 2'b00 || fim_posicao !== 1'b0 || db_estado !== 2'b00) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_bad_cycles got=%0d exp=0", bad); end
  endtask

  task automatic test_start();
    int bad = 0;
    do_reset();
    run_to(300);
    checks++; if (db_estado !== 2'b00) begin errors++; $display("FAIL start_c300_estado got=%0h exp=0", db_estado); end
    ligar = 1'b1;
    step();
    checks++; if (db_estado !== 2'b01) begin errors++; $display("FAIL start_c301_estado got=%0h exp=1", db_estado); end
    while (cyc < 1249) begin
      step();
      if (db_estado !== 2'b01) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL start_armado_cycles got=%0d exp=0", bad); end
    step();
    checks++; if (db_estado !== 2'b10) begin errors++; $display("FAIL start_c1250_estado got=%0h exp=2", db_estado); end
    bad = 0;
    while (cyc < 6249) begin
      step();
      if (largura !== 2'b00 || fim_posicao !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL start_hold_cycles got=%0d exp=0", bad); end
    step();
    checks++; if (largura !== 2'b01) begin errors++; $display("FAIL start_c6250_largura got=%0h exp=1", largura); end
    checks++; if (fim_posicao !== 1'b1) begin errors++; $display("FAIL start_c6250_fim got=%0b exp=1", fim_posicao); end
    step();
    checks++; if (fim_posicao !== 1'b0) begin errors++; $display("FAIL start_c6251_fim got=%0b exp=0", fim_posicao); end
  endtask

  task automatic test_full_sweep();
    logic [1:0] lar[7];
    logic       sen[7];
    lar = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00, 2'b01};
    sen = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int k = 1; k < 7; k++) begin
      run_to(6250 + 5000 * k - 1);
      checks++; if (largura !== lar[k-1]) begin errors++; $display("FAIL sweep%0d_pre got=%0h exp=%0h", k, largura, lar[k-1]); end
      step();
      checks++; if (largura !== lar[k]) begin errors++; $display("FAIL sweep%0d_largura got=%0h exp=%0h", k, largura, lar[k]); end
      checks++; if (sentido !== sen[k]) begin errors++; $display("FAIL sweep%0d_sentido got=%0b exp=%0b", k, sentido, sen[k]); end
      checks++; if (fim_posicao !== 1'b1) begin errors++; $display("FAIL sweep%0d_fim got=%0b exp=1", k, fim_posicao); end
      step();
      checks++; if (fim_posicao !== 1'b0) begin errors++; $display("FAIL sweep%0d_fim_next got=%0b exp=0", k, fim_posicao); end
    end
  endtask

  task automatic test_pause();
    int bad = 0;
    run_to(42000);
    checks++; if (largura !== 2'b10) begin errors++; $display("FAIL pause_pre_largura got=%0h exp=2", largura); end
    ligar = 1'b0;
    while (cyc < 45000) begin
      step();
      if (largura !== 2'b10 || db_estado !== 2'b00 || fim_posicao !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL pause_hold_cycles got=%0d exp=0", bad); end
    ligar = 1'b1;
    step();
    checks++; if (db_estado !== 2'b01) begin errors++; $display("FAIL pause_rearm got=%0h exp=1", db_estado); end
    run_to(46249);
    checks++; if (db_estado !== 2'b01) begin errors++; $display("FAIL pause_c46249_estado got=%0h exp=1", db_estado); end
    step();
    checks++; if (db_estado !== 2'b10) begin errors++; $display("FAIL pause_c46250_estado got=%0h exp=2", db_estado); end
    run_to(51249);
    checks++; if (largura !== 2'b10) begin errors++; $display("FAIL pause_c51249_largura got=%0h exp=2", largura); end
    step();
    checks++; if (largura !== 2'b11) begin errors++; $display("FAIL pause_c51250_largura got=%0h exp=3", largura); end
    checks++; if (sentido !== 1'b1) begin errors++; $display("FAIL pause_c51250_sentido got=%0b exp=1", sentido); end
    checks++; if (fim_posicao !== 1'b1) begin errors++; $display("FAIL pause_c51250_fim got=%0b exp=1", fim_posicao); end
  endtask

  task automatic test_reset_mid();
    run_to(56250);
    checks++; if (largura !== 2'b10 || sentido !== 1'b1) begin errors++; $display("FAIL mid_pre got=%0h/%0b exp=2/1", largura, sentido); end
    run_to(61249);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (largura !== 2'b00) begin errors++; $display("FAIL mid_largura got=%0h exp=0", largura); end
    checks++; if (sentido !== 1'b0) begin errors++; $display("FAIL mid_sentido got=%0b exp=0", sentido); end
    checks++; if (fim_posicao !== 1'b0) begin errors++; $display("FAIL mid_fim got=%0b exp=0", fim_posicao); end
    checks++; if (db_estado !== 2'b00) begin errors++; $display("FAIL mid_estado got=%0h exp=0", db_estado); end
  endtask

  task automatic test_small();
    logic [1:0] lar[7];
    logic       sen[7];
    lar = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00};
    sen = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    ligar = 1'b0;
    reset_s = 1'b1;
    ligar_s = 1'b1;
    step();
    step();
    reset_s = 1'b0;
    cyc = 0;
    run_to(3);
    checks++; if (db_s !== 2'b01) begin errors++; $display("FAIL small_c3_estado got=%0h exp=1", db_s); end
    step();
    checks++; if (db_s !== 2'b10) begin errors++; $display("FAIL small_c4_estado got=%0h exp=2", db_s); end
    for (int k = 1; k < 7; k++) begin
      run_to(4 + 4 * k - 1);
      checks++; if (largura_s !== lar[k-1]) begin errors++; $display("FAIL small%0d_pre got=%0h exp=%0h", k, largura_s, lar[k-1]); end
      step();
      checks++; if (largura_s !== lar[k] || sentido_s !== sen[k]) begin errors++; $display("FAIL small%0d_pos got=%0h/%0b exp=%0h/%0b", k, largura_s, sentido_s, lar[k], sen[k]); end
      checks++; if (fim_s !== 1'b1) begin errors++; $display("FAIL small%0d_fim got=%0b exp=1", k, fim_s); end
    end
  endtask

  initial begin
    reset   = 1'b1;
    ligar   = 1'b0;
    reset_s = 1'b1;
    ligar_s = 1'b0;
    test_reset();
    test_idle();
    test_start();
    test_full_sweep();
    test_pause();
    test_reset_mid();
    test_small();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
